io_rx_fifo_register: RTL

- Peripheral register in the reverse direction of a processor-written register: I/O logic writes, processor reads.
- I/O logic pushes words into a small synchronous FIFO; the processor pops them through a data register and monitors/controls the FIFO through a status/control register.
- Sits in the peripheral bank beside processor-written registers; provides an interrupt request when the fill level reaches a threshold or an overflow occurs.

---
 rtl/io_reg_pkg.sv | 25 ++
 rtl/sync_fifo_core.sv | 82 ++++++++
 rtl/io_rx_fifo_register.sv | 113 +++++++++++
 3 files changed

// File: rtl/io_reg_pkg.sv
// Shared definitions for the peripheral register bank:
// status/control bit positions and the status word layout.
package io_reg_pkg;

    localparam int STS_EMPTY = 0;
    localparam int STS_FULL  = 1;
    localparam int STS_OVF   = 2;
    localparam int STS_UDF   = 3;
    localparam int CTL_FLUSH = 4;

    localparam int CNT_LSB = 8;
    localparam int CNT_MSB = 15;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  count;
        logic [2:0]  rsvd_lo;
        logic        flush;
        logic        udf;
        logic        ovf;
        logic        full;
        logic        empty;
    } status_t;

endpackage

// File: rtl/sync_fifo_core.sv
// Small synchronous FIFO: storage, wrapping pointers, fill count,
// with flush taking priority over push and pop.
module sync_fifo_core #(
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_head,
    output logic [AW:0]   o_count,
    output logic [AW:0]   o_count_next,
    output logic          o_full,
    output logic          o_empty
);

    localparam int CW = AW + 1;
    localparam logic [AW:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_next;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = i_push & ~w_full & ~i_flush;
    assign w_pop   = i_pop & ~w_empty & ~i_flush;

    always_comb begin
        w_count_next = r_count;
        if (i_flush)
            w_count_next = '0;
        else if (w_push & ~w_pop)
            w_count_next = r_count + CNT_ONE;
        else if (w_pop & ~w_push)
            w_count_next = r_count - CNT_ONE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_next;
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset; count/empty gate every read of it.
    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head       = r_mem[r_rd_ptr];
    assign o_count      = r_count;
    assign o_count_next = w_count_next;
    assign o_full       = w_full;
    assign o_empty      = w_empty;

endmodule

// File: rtl/io_rx_fifo_register.sv
// I/O-to-processor receive register: I/O logic pushes into a FIFO,
// the processor pops via the data register and manages it via status.
module io_rx_fifo_register
    import io_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int THRESHOLD  = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Io_Valid,
    input  logic [DATA_WIDTH-1:0] Io_Data,
    output logic                  Io_Ready,
    input  logic                  Sys_RdEn,
    input  logic                  Sys_WrEn,
    input  logic [DATA_WIDTH-1:0] Sys_WrData,
    input  logic                  Sys_DataSelect,
    input  logic                  Sys_StatusSelect,
    output logic [DATA_WIDTH-1:0] Sys_RdData,
    output logic                  Sys_IntReq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] THR_CNT = CW'(THRESHOLD);

    logic [DATA_WIDTH-1:0] w_head;
    logic [AW:0]           w_count;
    logic [AW:0]           w_count_next;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop_req;
    logic                  w_ctl_wr;
    logic                  w_flush;
    logic                  w_ovf_set;
    logic                  w_udf_set;
    logic                  w_ovf_next;
    logic                  w_udf_next;
    logic                  r_ovf;
    logic                  r_udf;
    logic                  r_int;
    status_t               w_sts;

    assign Io_Ready  = ~w_full;
    assign w_push    = Io_Valid & Io_Ready;
    assign w_pop_req = Sys_RdEn & Sys_DataSelect;
    assign w_ctl_wr  = Sys_WrEn & Sys_StatusSelect;
    assign w_flush   = w_ctl_wr & Sys_WrData[CTL_FLUSH];

    // A refused offer is still an overflow, unless a flush swallows it.
    assign w_ovf_set = Io_Valid & w_full & ~w_flush;
    assign w_udf_set = w_pop_req & w_empty;

    assign w_ovf_next = w_ovf_set |
        (r_ovf & ~(w_ctl_wr & Sys_WrData[STS_OVF]));
    assign w_udf_next = w_udf_set |
        (r_udf & ~(w_ctl_wr & Sys_WrData[STS_UDF]));

    sync_fifo_core #(
        .DW    (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk        (Clock),
        .i_rst_n      (Reset),
        .i_push       (w_push),
        .i_pop        (w_pop_req),
        .i_flush      (w_flush),
        .i_data       (Io_Data),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_count_next (w_count_next),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
            r_int <= 1'b0;
        end else begin
            r_ovf <= w_ovf_next;
            r_udf <= w_udf_next;
            r_int <= (w_count_next >= THR_CNT) | w_ovf_next;
        end
    end

    always_comb begin
        w_sts       = '0;
        w_sts.empty = w_empty;
        w_sts.full  = w_full;
        w_sts.ovf   = r_ovf;
        w_sts.udf   = r_udf;
        w_sts.count = 8'(w_count);
    end

    always_comb begin
        Sys_RdData = '0;
        unique case (1'b1)
            Sys_DataSelect:
                Sys_RdData = w_empty ? '0 : w_head;
            Sys_StatusSelect:
                Sys_RdData = DATA_WIDTH'(w_sts);
            default:
                Sys_RdData = '0;
        endcase
    end

    assign Sys_IntReq = r_int;

endmodule
